// File: rtl/div32_seq.sv
// div32_seq: sequential unsigned restoring divider.
// Produces one quotient bit per clock over WIDTH iterations. A start strobe
// is accepted in IDLE or DONE. Divide-by-zero completes in a single cycle.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset, clears all state
//   start        request strobe, sampled only in IDLE or DONE
//   dividend     unsigned dividend, captured on accept
//   divisor      unsigned divisor, captured on accept
//   busy         high while iterating
//   done         high for the cycle the results become valid (state DONE)
//   div_by_zero  registered with done, set when the captured divisor was 0
//   quotient     unsigned quotient, held until the next completion
//   remainder    unsigned remainder, held until the next completion
module div32_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] rem_acc;
    logic [WIDTH-1:0] q_acc;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] q_next;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and keep the subtraction only if it did not go negative.
    always_comb begin
        shifted  = {rem_acc, q_acc[WIDTH-1]};
        trial    = shifted - {1'b0, dvs};
        rem_next = shifted[WIDTH-1:0];
        q_next   = {q_acc[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            rem_next = trial[WIDTH-1:0];
            q_next   = {q_acc[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            rem_acc     <= '0;
            q_acc       <= '0;
            dvs         <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (divisor != '0) begin
                            rem_acc <= '0;
                            q_acc   <= dividend;
                            dvs     <= divisor;
                            count   <= '0;
                            busy    <= 1'b1;
                            done    <= 1'b0;
                            state   <= RUN;
                        end else begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            state       <= DONE;
                        end
                    end else begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    rem_acc <= rem_next;
                    q_acc   <= q_next;
                    count   <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        quotient    <= q_next;
                        remainder   <= rem_next;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div32_seq.sv
// tb_div32_seq: scoreboard bench for div32_seq. The driver pushes the
// expected result and completion cycle for every accepted start; a monitor
// on the falling edge pops and compares whenever done is high, and checks
// busy and output stability every cycle.
module tb_div32_seq;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] quotient;
    logic [31:0] remainder;

    div32_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          t;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int bs = -100;
    logic [31:0] hq = '0;
    logic [31:0] hr = '0;
    logic        hz = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int t);
        exp_t e;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
            e.z = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 1'b0;
        end
        e.t = t;
        return e;
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (!reset_n) begin
            hq = '0;
            hr = '0;
            hz = 1'b0;
        end else begin
            chk("busy", 32'(busy), 32'((cyc >= bs) && (cyc < bs + 32)));
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done: got done=1 expected no pending result (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(e.t));
                    chk("quotient", quotient, e.q);
                    chk("remainder", remainder, e.r);
                    chk("div_by_zero", 32'(div_by_zero), 32'(e.z));
                end
                hq = quotient;
                hr = remainder;
                hz = div_by_zero;
            end else begin
                chk("hold_quotient", quotient, hq);
                chk("hold_remainder", remainder, hr);
                chk("hold_dbz", 32'(div_by_zero), 32'(hz));
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (b == 32'd0) begin
            sb.push_back(model(a, b, cyc));
        end else begin
            sb.push_back(model(a, b, cyc + 32));
            bs = cyc;
        end
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    task automatic wait_empty(input int lim);
        for (int i = 0; i < lim; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
            #1;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL timeout: got %0d results pending expected 0 (cycle %0d)", sb.size(), cyc);
            sb.delete();
        end
    endtask

    initial begin
        #3_000_000;
        errors++;
        $display("FAIL watchdog: got no completion expected finish (cycle %0d)", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int c;
        reset_n  = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic and extremes
        issue(32'd100, 32'd7);                       wait_empty(40);
        issue(32'hFFFF_FFFF, 32'd1);                 wait_empty(40);
        issue(32'd5, 32'hFFFF_FFFF);                 wait_empty(40);
        issue(32'h8000_0000, 32'h8000_0001);         wait_empty(40);
        issue(32'd1234, 32'd0);                      wait_empty(5);
        issue(32'd0, 32'd9);                         wait_empty(40);

        // Start during RUN is ignored
        issue(32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        start    = 1'b1;
        dividend = 32'd5;
        divisor  = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_empty(40);

        // Start held through DONE: second division accepted at the DONE edge
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd100;
        divisor  = 32'd7;
        @(posedge clk);
        #1;
        c  = cyc;
        bs = c;
        sb.push_back(model(32'd100, 32'd7, c + 32));
        sb.push_back(model(32'd1000, 32'd10, c + 65));
        dividend = 32'd1000;
        divisor  = 32'd10;
        repeat (33) @(posedge clk);
        #1;
        bs    = cyc;
        start = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        wait_empty(80);

        // Reset mid-RUN
        issue(32'd100, 32'd7);
        repeat (14) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_dbz", 32'(div_by_zero), 32'd0);
        chk("midrst_quotient", quotient, 32'd0);
        chk("midrst_remainder", remainder, 32'd0);
        sb.delete();
        bs = -100;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        issue(32'd1000, 32'd10);
        wait_empty(40);

        // Randomized pairs, divisor magnitudes spread across the range
        for (int i = 0; i < 1500; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (b == 32'd0) b = 32'd1;
            if ((i % 5) == 0) a = a >> $urandom_range(0, 31);
            issue(a, b);
            wait_empty(40);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
